// File: rtl/sm2_pkg.sv
// Shared constants and FSM state type for the SM2 prime-field fast reduction.
// SM2_RED_DOUBLE_FOLD_EN selects two fold steps per FOLD cycle.
package sm2_pkg;

    localparam int SM2_PROD_W = 512;
    localparam int SM2_RES_W  = 256;

    // p = 2^256 - 2^224 - 2^96 + 2^64 - 1
    localparam logic [SM2_RES_W-1:0] SM2_P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

`ifdef SM2_RED_DOUBLE_FOLD_EN
    localparam int unsigned SM2_FOLD_MAX = 6;
`else
    localparam int unsigned SM2_FOLD_MAX = 12;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StFold,
        StCorr,
        StDone
    } sm2_state_e;

    function automatic logic sm2_hi_zero(input logic [SM2_PROD_W-1:0] v);
        return v[SM2_PROD_W-1:SM2_RES_W] == '0;
    endfunction

endpackage

// File: rtl/sm2_fold.sv
// One combinational fold step: lo + hi*(2^224 + 2^96 - 2^64 + 1), using 2^256 == that mod p.
module sm2_fold
    import sm2_pkg::*;
(
    input  logic [SM2_PROD_W-1:0] value,
    output logic [SM2_PROD_W-1:0] folded
);

    logic [SM2_PROD_W-1:0] hi_w;
    logic [SM2_PROD_W-1:0] lo_w;

    always_comb begin
        hi_w = {{SM2_RES_W{1'b0}}, value[SM2_PROD_W-1:SM2_RES_W]};
        lo_w = {{SM2_RES_W{1'b0}}, value[SM2_RES_W-1:0]};
        // The true sum is non-negative and below 2^482, so modular 512-bit math is exact.
        folded = lo_w + (hi_w << 224) + (hi_w << 96) + hi_w - (hi_w << 64);
    end

endmodule

// File: rtl/sm2_fast_red.sv
// Sequential SM2 reduction: c mod p via repeated folding then one conditional subtract.
// Define SM2_RED_DOUBLE_FOLD_EN to chain two fold steps per FOLD cycle.
module sm2_fast_red
    import sm2_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SM2_PROD_W-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SM2_RES_W-1:0]  out_data
);

    localparam logic [3:0] FOLD_LAST = 4'(SM2_FOLD_MAX - 1);

    sm2_state_e            state_q, state_d;
    logic [SM2_PROD_W-1:0] acc_q, acc_d;
    logic [SM2_RES_W-1:0]  result_q, result_d;
    logic [3:0]            fold_cnt_q, fold_cnt_d;

    logic [SM2_PROD_W-1:0] fold_a;
    logic [SM2_PROD_W-1:0] fold_next;
    logic [SM2_RES_W-1:0]  acc_lo;

    sm2_fold u_fold_a (
        .value  (acc_q),
        .folded (fold_a)
    );

`ifdef SM2_RED_DOUBLE_FOLD_EN
    logic [SM2_PROD_W-1:0] fold_b;

    sm2_fold u_fold_b (
        .value  (fold_a),
        .folded (fold_b)
    );

    always_comb begin
        fold_next = sm2_hi_zero(fold_a) ? fold_a : fold_b;
    end
`else
    always_comb begin
        fold_next = fold_a;
    end
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        result_d   = result_q;
        fold_cnt_d = fold_cnt_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        acc_lo     = acc_q[SM2_RES_W-1:0];

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d      = in_data;
                    fold_cnt_d = '0;
                    state_d    = StFold;
                end
            end
            StFold: begin
                // Counter exit is a hard bound; hi reaches zero well before it.
                if (sm2_hi_zero(acc_q) || fold_cnt_q == FOLD_LAST) begin
                    state_d = StCorr;
                end else begin
                    acc_d      = fold_next;
                    fold_cnt_d = fold_cnt_q + 4'd1;
                end
            end
            StCorr: begin
                // acc < 2^256 < 2p, so one subtraction is enough.
                result_d = (acc_lo >= SM2_P) ? acc_lo - SM2_P : acc_lo;
                state_d  = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                out_data  = result_q;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            result_q   <= '0;
            fold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
            fold_cnt_q <= fold_cnt_d;
        end
    end

endmodule

// File: tb/tb_sm2_fast_red.sv
// Directed-table and random bench for sm2_fast_red; golden model is c % p.
module tb_sm2_fast_red;

    localparam logic [255:0] P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
`ifdef SM2_RED_DOUBLE_FOLD_EN
    localparam int MaxLat = 8;
`else
    localparam int MaxLat = 14;
`endif
    localparam int NumRand = 2000;

    typedef struct {
        logic [511:0] c;
        logic [255:0] r;
        int           lat;  // 0 = only bound-checked
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;

    int           errors;
    int           checks;
    vec_t         vecs[9];
    logic [511:0] pw;
    logic [511:0] pm1;
    logic [511:0] ones;
    logic [511:0] rc;
    logic [255:0] r;
    int           lat;
    bit           ok;

    sm2_fast_red dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] golden(input logic [511:0] c);
        logic [511:0] m;
        m = c % {256'd0, P};
        return m[255:0];
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge after the result is consumed.
    task automatic run_op(input logic [511:0] c, input int hold, output logic [255:0] res,
                          output int latency, output bit busy_ok);
        busy_ok = in_ready;
        in_valid = 1'b1;
        in_data  = c;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~c;
        latency  = 1;
        while (!out_valid && latency < 40) begin
            if (in_ready) busy_ok = 1'b0;
            @(negedge clk);
            latency++;
        end
        res = out_data;
        for (int i = 0; i < hold; i++) begin
            in_valid = (i % 3 == 0);
            in_data  = {16{$urandom()}};
            @(negedge clk);
            if (!out_valid || in_ready || out_data !== res) busy_ok = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_in_ready", 256'(in_ready), 256'd1);
        chk("reset_out_valid", 256'(out_valid), 256'd0);
        chk("reset_out_data", out_data, 256'd0);

        pw   = {256'd0, P};
        pm1  = pw - 512'd1;
        ones = '1;
        vecs[0] = '{512'd0, 256'd0, 3};
        vecs[1] = '{512'd7, 256'd7, 3};
        vecs[2] = '{pw, 256'd0, 3};
        vecs[3] = '{pw + 512'd5, 256'd5, 3};
        vecs[4] = '{pm1, P - 256'd1, 3};
        vecs[5] = '{(512'd1 << 256) - 512'd1,
                    (256'd1 << 224) + (256'd1 << 96) - (256'd1 << 64), 3};
        vecs[6] = '{512'd1 << 256,
                    (256'd1 << 224) + (256'd1 << 96) - (256'd1 << 64) + 256'd1, 4};
        vecs[7] = '{pm1 * pm1, 256'd1, 0};
        vecs[8] = '{ones, golden(ones), 0};

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].c, 0, r, lat, ok);
            chk($sformatf("vec%0d_result", i), r, vecs[i].r);
            if (vecs[i].lat != 0) chk($sformatf("vec%0d_latency", i), 256'(lat), 256'(vecs[i].lat));
            else chk($sformatf("vec%0d_lat_bound", i), 256'(lat <= MaxLat), 256'd1);
            chk($sformatf("vec%0d_busy", i), 256'(ok), 256'd1);
            chk($sformatf("vec%0d_idle_after", i), {254'd0, out_valid, in_ready}, 256'd1);
        end

        // Backpressure: 20 cycles in DONE with in_valid pulses that must be ignored.
        run_op(512'd1 << 256, 20, r, lat, ok);
        chk("hold_result", r, (256'd1 << 224) + (256'd1 << 96) - (256'd1 << 64) + 256'd1);
        chk("hold_stable_not_ready", 256'(ok), 256'd1);
        chk("hold_idle_after", {254'd0, out_valid, in_ready}, 256'd1);

        // One-cycle reset in the middle of FOLD.
        in_valid = 1'b1;
        in_data  = ones;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_fold_idle", {254'd0, out_valid, in_ready}, 256'd1);
        chk("rst_mid_fold_data", out_data, 256'd0);
        run_op(512'd7, 0, r, lat, ok);
        chk("after_rst_result", r, 256'd7);
        chk("after_rst_latency", 256'(lat), 256'd3);

        for (int n = 0; n < NumRand; n++) begin
            for (int w = 0; w < 16; w++) rc[w*32 +: 32] = $urandom();
            if (n % 4 == 0) rc = rc >> $urandom_range(0, 511);
            run_op(rc, 0, r, lat, ok);
            chk($sformatf("rand%0d_result", n), r, golden(rc));
            chk($sformatf("rand%0d_lat_bound", n), 256'(lat <= MaxLat && ok), 256'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
